// File: rtl/impl_window_checker.sv
// impl_window_checker
// Multi-channel implication monitor: per channel, checks that a trigger on ant is followed by
// cons within MIN_DLY..MAX_DLY clocks. Each channel triggers on the ant level or on its rising
// edge, selected by EDGE_MODE.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   en                1 = new attempts may start; in-flight attempts always resolve
//   clr_cnt           synchronous clear of counters and any_fail (pending attempts kept)
//   ant, cons         per-channel antecedent / consequent
//   pass_pulse        per-channel one-cycle pulse: >=1 attempt satisfied on the previous edge
//   fail_pulse        per-channel one-cycle pulse: an attempt expired on the previous edge
//   pass_cnt          packed saturating pass counters, channel i at [i*CNT_W +: CNT_W]
//   fail_cnt          packed saturating fail counters, same packing
//   any_fail          sticky OR of all failures since rst / clr_cnt
module impl_window_checker #(
    parameter int unsigned     N_CH      = 4,
    parameter int unsigned     MIN_DLY   = 1,
    parameter int unsigned     MAX_DLY   = 1,
    parameter int unsigned     CNT_W     = 16,
    parameter logic [N_CH-1:0] EDGE_MODE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr_cnt,
    input  logic [N_CH-1:0]        ant,
    input  logic [N_CH-1:0]        cons,
    output logic [N_CH-1:0]        pass_pulse,
    output logic [N_CH-1:0]        fail_pulse,
    output logic [N_CH*CNT_W-1:0]  pass_cnt,
    output logic [N_CH*CNT_W-1:0]  fail_cnt,
    output logic                   any_fail
);

    if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > 16) begin : g_param_check
        $fatal(1, "impl_window_checker: need 1 <= MIN_DLY <= MAX_DLY <= 16");
    end

    localparam int unsigned      PopW   = $clog2(MAX_DLY + 1);
    localparam int unsigned      SumW   = CNT_W + PopW;
    localparam logic [CNT_W-1:0] CntMax = '1;

    // pend_q[ch][k] = 1: attempt triggered k edges ago, still unresolved
    logic [N_CH-1:0][MAX_DLY:1] pend_q, pend_d;
    logic [N_CH-1:0]            ant_q, ant_d;
    logic [N_CH-1:0]            pass_pulse_q, pass_pulse_d;
    logic [N_CH-1:0]            fail_pulse_q, fail_pulse_d;
    logic [N_CH-1:0][CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [N_CH-1:0][CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic                       any_fail_q, any_fail_d;

    logic [N_CH-1:0]            trig;
    logic [N_CH-1:0]            expd;
    logic [N_CH-1:0][PopW-1:0]  pop;
    logic [N_CH-1:0][SumW-1:0]  pass_sum;

    always_comb begin
        ant_d        = ant;
        pend_d       = '0;
        trig         = '0;
        expd         = '0;
        pop          = '0;
        pass_sum     = '0;
        pass_pulse_d = '0;
        fail_pulse_d = '0;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        any_fail_d   = any_fail_q;

        for (int ch = 0; ch < N_CH; ch++) begin
            trig[ch] = en & ant[ch] & (~EDGE_MODE[ch] | ~ant_q[ch]);

            // One cons sample satisfies every attempt currently inside the window.
            for (int unsigned k = MIN_DLY; k <= MAX_DLY; k++) begin
                pop[ch]          = pop[ch] + PopW'(pend_q[ch][k] & cons[ch]);
                pass_pulse_d[ch] = pass_pulse_d[ch] | (pend_q[ch][k] & cons[ch]);
            end
            expd[ch]         = pend_q[ch][MAX_DLY] & ~cons[ch];
            fail_pulse_d[ch] = expd[ch];

            // Shift by one edge; in-window attempts satisfied this edge are dropped. The oldest
            // slot always falls off since it either passed or expired above.
            pend_d[ch][1] = trig[ch];
            for (int unsigned k = 2; k <= MAX_DLY; k++) begin
                if (k - 1 >= MIN_DLY) begin
                    pend_d[ch][k] = pend_q[ch][k-1] & ~cons[ch];
                end else begin
                    pend_d[ch][k] = pend_q[ch][k-1];
                end
            end

            pass_sum[ch]   = SumW'(pass_cnt_q[ch]) + SumW'(pop[ch]);
            pass_cnt_d[ch] = (pass_sum[ch] > SumW'(CntMax)) ? CntMax : pass_sum[ch][CNT_W-1:0];
            if (expd[ch] && (fail_cnt_q[ch] != CntMax)) begin
                fail_cnt_d[ch] = fail_cnt_q[ch] + CNT_W'(1);
            end
        end

        if (|expd) begin
            any_fail_d = 1'b1;
        end

        // Clear wins over this edge's updates; pulses are unaffected.
        if (clr_cnt) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            any_fail_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            ant_q        <= '0;
            pass_pulse_q <= '0;
            fail_pulse_q <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            any_fail_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            ant_q        <= ant_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            any_fail_q   <= any_fail_d;
        end
    end

    assign pass_pulse = pass_pulse_q;
    assign fail_pulse = fail_pulse_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign any_fail   = any_fail_q;

endmodule

// File: doc/impl_window_checker.md
Name: impl_window_checker

Overview:
- Synthesizable multi-channel implication monitor. Per channel it checks the property "antecedent implies consequent within MIN_DLY..MAX_DLY clocks".
- Each channel checks in either level mode or rising-edge mode.
- Sits beside DUT blocks as an on-chip checker and as a bench-side scoreboard. It reports per-attempt pass/fail pulses, saturating counters and a sticky error flag.

Parameters:
- N_CH, 4, number of independent channels
- MIN_DLY, 1, earliest clock after the trigger at which the consequent may satisfy the attempt (>=1)
- MAX_DLY, 1, latest clock after the trigger; must be >= MIN_DLY, <= 16
- CNT_W, 16, width of each pass/fail counter
- EDGE_MODE, 0, per-channel N_CH-bit mask. Bit i=1: trigger on rising edge of ant[i]. Bit i=0: trigger on every sampled high level.

Ports:
- clk  in  1  system clock; all sampling on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = new attempts may start; pending attempts always complete
- clr_cnt  in  1  synchronous clear of counters and sticky flag
- ant  in  N_CH  antecedent per channel
- cons  in  N_CH  consequent per channel
- pass_pulse  out  N_CH  one-cycle pulse: >=1 attempt on channel satisfied this edge
- fail_pulse  out  N_CH  one-cycle pulse: >=1 attempt on channel expired unsatisfied
- pass_cnt  out  N_CH*CNT_W  packed per-channel pass counters; channel i in bits [i*CNT_W +: CNT_W]
- fail_cnt  out  N_CH*CNT_W  packed per-channel fail counters, same packing
- any_fail  out  1  sticky OR of all failures since reset/clr_cnt

Behaviour:
- Reset: all outputs 0, pending shift registers 0, ant_q (previous sample) 0. An rst asserted mid-attempt discards all pending attempts with no pass/fail reported.
- Trigger at edge t, channel i:
  - Level mode: en & ant[i].
  - Edge mode: en & ant[i] & ~ant_q[i].
  - ant_q updates every edge regardless of en.
- Pending tracking: per channel, bit vector pend[1..MAX_DLY]. pend[k]=1 means an attempt was triggered k edges ago and is unresolved. Each edge the vector shifts by one; the trigger enters pend[1] for the next edge.
- Evaluation at each edge, channel i:
  - sat = OR over k in MIN_DLY..MAX_DLY of (pend[k] & cons[i]). All such attempts resolve as pass and are cleared; one cons sample satisfies every in-window attempt.
  - A cons sample with pend[k], k<MIN_DLY, has no effect on that attempt.
  - exp = pend[MAX_DLY] & ~cons[i]. The attempt resolves as fail.
- Outputs registered; latency is one edge:
  - pass_pulse[i]/fail_pulse[i] are high in the cycle after the evaluating edge, for exactly one cycle.
  - Both may be high together when different attempts resolve on the same edge.
- Counters:
  - pass_cnt[i] += number of attempts passed that edge (popcount); fail_cnt[i] += 1 per expired attempt (max 1/edge).
  - Counters saturate at 2^CNT_W-1 and never wrap.
- any_fail: set on any fail; held until rst or clr_cnt.
- clr_cnt: zeroes counters and any_fail on that edge; pending attempts are untouched. Counting resumes the next edge. A fail on the same edge as clr_cnt is lost from the counters but still pulses.
- Simultaneous trigger and resolution on one channel is legal. The new attempt enters pend[1]; resolution uses the old vector.
- en=0: no new attempts start; in-flight attempts still resolve.
- Channels are fully independent.
- Elaboration: MIN_DLY<1 or MAX_DLY<MIN_DLY -> $fatal.

Test Plan:
- N_CH=1, MIN=MAX=1, level; ant high at edges 1-3, cons high at edges 3-6 -> fail_pulse after edge 2, pass_pulse after edges 3 and 4; final pass_cnt=2, fail_cnt=1, any_fail=1.
- Same stimulus, EDGE_MODE=1 -> single attempt from edge 1 fails at edge 2; pass_cnt=0, fail_cnt=1.
- MIN=2, MAX=4; ant pulse at edge 10, cons only at edge 11 -> no pass, fail at edge 14. Repeat with cons at edge 13 -> pass at edge 13, no fail.
- MIN=2, MAX=4, level; ant high at edges 10 and 11, cons at edge 13 -> one pass_pulse, pass_cnt increments by 2, no fail.
- CNT_W=4; 20 consecutive failing attempts -> fail_cnt holds 15. Then clr_cnt -> fail_cnt=0, any_fail=0.
- ant at edge 10, rst at edge 12, cons at edge 13 -> no pulses, counters 0. Separately, en=0 at edge 10 with ant high -> no attempt, while an attempt started at edge 9 still resolves.
